// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Bundle of per-stage instruction fields, the start pulse and
//                the stage-register controls exchanged between the Y86-64
//                pipeline datapath (master) and pipe_ctrl (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    // Pipeline fields and start pulse, driven by the datapath
    logic        go;
    logic [3:0]  d_icode;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  e_icode;
    logic [3:0]  e_dstM;
    logic        e_cnd;
    logic [3:0]  m_icode;
    logic [2:0]  m_stat;
    logic [2:0]  w_stat;
    logic [3:0]  w_icode;

    // Stage-register controls and status, driven by pipe_ctrl
    logic        f_stall;
    logic        d_stall;
    logic        d_bubble;
    logic        e_bubble;
    logic        m_bubble;
    logic        w_stall;
    logic        cc_en;
    logic        halted;
    logic [2:0]  final_stat;
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;
    logic [31:0] lu_cnt;
    logic [31:0] mp_cnt;

    modport master (
        output go, d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cnd,
               m_icode, m_stat, w_stat, w_icode,
        input  f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall,
               cc_en, halted, final_stat, cyc_cnt, ret_cnt, lu_cnt, mp_cnt
    );

    modport slave (
        input  go, d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cnd,
               m_icode, m_stat, w_stat, w_icode,
        output f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall,
               cc_en, halted, final_stat, cyc_cnt, ret_cnt, lu_cnt, mp_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Y86-64 five-stage pipeline control. Produces stall/bubble
//                controls for the F/D/E/M/W registers, gates the condition
//                code write, and runs an IDLE/RUN/HALTED sequencer that keeps
//                the pipe bubbling until 'go' and freezes it once a non-AOK
//                status reaches write-back.
//                Optional macro PIPE_PERF_CNT_EN builds four 32-bit
//                performance counters; without it the counter outputs are 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    // Instruction codes
    localparam logic [3:0] C_I_NOP    = 4'h1;
    localparam logic [3:0] C_I_MRMOVQ = 4'h5;
    localparam logic [3:0] C_I_OPQ    = 4'h6;
    localparam logic [3:0] C_I_JXX    = 4'h7;
    localparam logic [3:0] C_I_RET    = 4'h9;
    localparam logic [3:0] C_I_POPQ   = 4'hB;

    // Status codes and "no register"
    localparam logic [2:0] C_S_AOK = 3'd1;
    localparam logic [2:0] C_S_HLT = 3'd2;
    localparam logic [2:0] C_S_ADR = 3'd3;
    localparam logic [2:0] C_S_INS = 3'd4;
    localparam logic [3:0] C_RNONE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_halted;
    logic [2:0] r_final_stat;

    logic w_load_use;
    logic w_ret_in;
    logic w_mispred;
    logic w_m_exc;
    logic w_w_exc;

    logic w_f_stall;
    logic w_d_stall;
    logic w_d_bubble;
    logic w_e_bubble;
    logic w_m_bubble;
    logic w_w_stall;
    logic w_cc_en;

    // Hazard detection from the current per-stage fields
    always_comb begin
        w_load_use = ((bus.e_icode == C_I_MRMOVQ) || (bus.e_icode == C_I_POPQ)) &&
                     (bus.e_dstM != C_RNONE) &&
                     ((bus.e_dstM == bus.d_srcA) || (bus.e_dstM == bus.d_srcB));
        w_ret_in   = (bus.d_icode == C_I_RET) || (bus.e_icode == C_I_RET) ||
                     (bus.m_icode == C_I_RET);
        w_mispred  = (bus.e_icode == C_I_JXX) && !bus.e_cnd;
        w_m_exc    = (bus.m_stat == C_S_HLT) || (bus.m_stat == C_S_ADR) ||
                     (bus.m_stat == C_S_INS);
        w_w_exc    = (bus.w_stat == C_S_HLT) || (bus.w_stat == C_S_ADR) ||
                     (bus.w_stat == C_S_INS);
    end

    // Stage controls: hazard-driven in RUN, fixed bubble/freeze patterns otherwise.
    // d_bubble is masked by load_use so a D stall always wins over a D bubble.
    always_comb begin
        w_f_stall  = 1'b1;
        w_d_stall  = 1'b0;
        w_d_bubble = 1'b1;
        w_e_bubble = 1'b1;
        w_m_bubble = 1'b1;
        w_w_stall  = 1'b0;
        w_cc_en    = 1'b0;
        case (r_state)
            S_RUN: begin
                w_f_stall  = w_load_use | w_ret_in;
                w_d_stall  = w_load_use;
                w_d_bubble = w_mispred | (w_ret_in & ~w_load_use);
                w_e_bubble = w_mispred | w_load_use;
                w_m_bubble = w_m_exc | w_w_exc;
                w_w_stall  = w_w_exc;
                w_cc_en    = (bus.e_icode == C_I_OPQ) & ~w_m_exc & ~w_w_exc;
            end
            S_HALTED: begin
                w_w_stall  = 1'b1;
            end
            default: begin
                w_w_stall  = 1'b0;
            end
        endcase
    end

    assign bus.f_stall    = w_f_stall;
    assign bus.d_stall    = w_d_stall;
    assign bus.d_bubble   = w_d_bubble;
    assign bus.e_bubble   = w_e_bubble;
    assign bus.m_bubble   = w_m_bubble;
    assign bus.w_stall    = w_w_stall;
    assign bus.cc_en      = w_cc_en;
    assign bus.halted     = r_halted;
    assign bus.final_stat = r_final_stat;

    // Run/halt sequencer; the halting status is captured on the halting edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_halted     <= 1'b0;
            r_final_stat <= C_S_AOK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.go) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_w_exc) begin
                        r_state      <= S_HALTED;
                        r_halted     <= 1'b1;
                        r_final_stat <= bus.w_stat;
                    end
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_ret_cnt;
    logic [31:0] r_lu_cnt;
    logic [31:0] r_mp_cnt;
    logic        w_retire;

    assign w_retire = (bus.w_icode != C_I_NOP) & ~w_w_exc & ~w_w_stall;

    // Performance counters: cleared on start, counting only while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt <= 32'd0;
            r_ret_cnt <= 32'd0;
            r_lu_cnt  <= 32'd0;
            r_mp_cnt  <= 32'd0;
        end else if ((r_state == S_IDLE) && bus.go) begin
            r_cyc_cnt <= 32'd0;
            r_ret_cnt <= 32'd0;
            r_lu_cnt  <= 32'd0;
            r_mp_cnt  <= 32'd0;
        end else if (r_state == S_RUN) begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (w_retire) begin
                r_ret_cnt <= r_ret_cnt + 32'd1;
            end
            if (w_load_use) begin
                r_lu_cnt <= r_lu_cnt + 32'd1;
            end
            if (w_mispred) begin
                r_mp_cnt <= r_mp_cnt + 32'd1;
            end
        end
    end

    assign bus.cyc_cnt = r_cyc_cnt;
    assign bus.ret_cnt = r_ret_cnt;
    assign bus.lu_cnt  = r_lu_cnt;
    assign bus.mp_cnt  = r_mp_cnt;
`else
    // Write-back icode only feeds the retire counter, absent in this build
    logic w_unused_w_icode;
    assign w_unused_w_icode = &{1'b0, bus.w_icode};

    assign bus.cyc_cnt = 32'd0;
    assign bus.ret_cnt = 32'd0;
    assign bus.lu_cnt  = 32'd0;
    assign bus.mp_cnt  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl: directed scenarios plus
//                randomized pipeline fields compared against a behavioural
//                model of the run/halt rules and hazard equations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: 0 = idle, 1 = running, 2 = halted
    int          m_mode;
    logic        m_halted;
    logic [2:0]  m_final;
    logic [31:0] m_cyc, m_ret, m_lu, m_mp;

    logic [3:0] icodes [7] = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_exc(input logic [2:0] s);
        return (s >= 3'd2) && (s <= 3'd4);
    endfunction

    function automatic logic lu_now();
        return (bus.e_icode inside {4'h5, 4'hB}) && (bus.e_dstM != 4'hF) &&
               ((bus.e_dstM == bus.d_srcA) || (bus.e_dstM == bus.d_srcB));
    endfunction

    function automatic logic ret_now();
        return (bus.d_icode == 4'h9) || (bus.e_icode == 4'h9) || (bus.m_icode == 4'h9);
    endfunction

    function automatic logic mp_now();
        return (bus.e_icode == 4'h7) && !bus.e_cnd;
    endfunction

    // Expected {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, cc_en}
    function automatic logic [6:0] exp_ctrl();
        logic lu, rt, mp, me, we;
        lu = lu_now(); rt = ret_now(); mp = mp_now();
        me = is_exc(bus.m_stat); we = is_exc(bus.w_stat);
        if (m_mode == 0) return 7'b1011100;
        if (m_mode == 2) return 7'b1011110;
        return {lu | rt, lu, mp | (rt & !lu), mp | lu, me | we, we,
                (bus.e_icode == 4'h6) & !me & !we};
    endfunction

    function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef PIPE_PERF_CNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0; m_halted = 1'b0; m_final = 3'd1;
        m_cyc = 0; m_ret = 0; m_lu = 0; m_mp = 0;
    endtask

    // Apply the rules for one rising edge using the inputs present at that edge
    task automatic model_step();
        if (m_mode == 0) begin
            if (bus.go) begin
                m_mode = 1;
                m_cyc = 0; m_ret = 0; m_lu = 0; m_mp = 0;
            end
        end else if (m_mode == 1) begin
            m_cyc = m_cyc + 1;
            if (lu_now()) m_lu = m_lu + 1;
            if (mp_now()) m_mp = m_mp + 1;
            if (bus.w_icode != 4'h1 && !is_exc(bus.w_stat)) m_ret = m_ret + 1;
            if (is_exc(bus.w_stat)) begin
                m_mode = 2; m_halted = 1'b1; m_final = bus.w_stat;
            end
        end
    endtask

    task automatic check_all();
        logic [6:0] e;
        e = exp_ctrl();
        chk("f_stall",  {31'd0, bus.f_stall},  {31'd0, e[6]});
        chk("d_stall",  {31'd0, bus.d_stall},  {31'd0, e[5]});
        chk("d_bubble", {31'd0, bus.d_bubble}, {31'd0, e[4]});
        chk("e_bubble", {31'd0, bus.e_bubble}, {31'd0, e[3]});
        chk("m_bubble", {31'd0, bus.m_bubble}, {31'd0, e[2]});
        chk("w_stall",  {31'd0, bus.w_stall},  {31'd0, e[1]});
        chk("cc_en",    {31'd0, bus.cc_en},    {31'd0, e[0]});
        chk("d_stall_and_bubble", {31'd0, bus.d_stall & bus.d_bubble}, 32'd0);
        chk("halted",     {31'd0, bus.halted},     {31'd0, m_halted});
        chk("final_stat", {29'd0, bus.final_stat}, {29'd0, m_final});
        chk("cyc_cnt", bus.cyc_cnt, cexp(m_cyc));
        chk("ret_cnt", bus.ret_cnt, cexp(m_ret));
        chk("lu_cnt",  bus.lu_cnt,  cexp(m_lu));
        chk("mp_cnt",  bus.mp_cnt,  cexp(m_mp));
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge
    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic benign();
        bus.go = 1'b0;
        bus.d_icode = 4'h1; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
        bus.e_icode = 4'h1; bus.e_dstM = 4'hF; bus.e_cnd = 1'b1;
        bus.m_icode = 4'h1; bus.m_stat = 3'd1;
        bus.w_stat = 3'd1; bus.w_icode = 4'h1;
    endtask

    // Asynchronous reset between clock edges, with go raised alongside to show rst wins
    task automatic async_reset();
        #2 rst = 1'b1;
        bus.go = 1'b1;
        #1 model_reset();
        check_all();
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_final",  {29'd0, bus.final_stat}, 32'd1);
        chk("rst_cyc",    bus.cyc_cnt, 32'd0);
        chk("rst_fstall", {31'd0, bus.f_stall}, 32'd1);
        bus.go = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [3:0] rnd_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : r[3:0];
    endfunction

    function automatic logic [2:0] rnd_stat(input int one_in);
        if ($urandom_range(1, one_in) == 1) return 3'($urandom_range(2, 4));
        return 3'd1;
    endfunction

    initial begin
        int halt_ticks;
        rst = 1'b1;
        benign();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset then idle
        repeat (5) tick();
        #1;
        chk("idle_halted",   {31'd0, bus.halted},   32'd0);
        chk("idle_f_stall",  {31'd0, bus.f_stall},  32'd1);
        chk("idle_d_bubble", {31'd0, bus.d_bubble}, 32'd1);
        chk("idle_w_stall",  {31'd0, bus.w_stall},  32'd0);

        // Start
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;

        // Load-use
        bus.e_icode = 4'h5; bus.e_dstM = 4'h3; bus.d_srcA = 4'h3;
        #1;
        chk("lu_f_stall",  {31'd0, bus.f_stall},  32'd1);
        chk("lu_d_stall",  {31'd0, bus.d_stall},  32'd1);
        chk("lu_e_bubble", {31'd0, bus.e_bubble}, 32'd1);
        chk("lu_d_bubble", {31'd0, bus.d_bubble}, 32'd0);
        tick();
        benign();
        chk("lu_cnt_step", bus.lu_cnt, cexp(32'd1));

        // Mispredict plus RET in M
        bus.e_icode = 4'h7; bus.e_cnd = 1'b0; bus.m_icode = 4'h9;
        #1;
        chk("mp_d_bubble", {31'd0, bus.d_bubble}, 32'd1);
        chk("mp_e_bubble", {31'd0, bus.e_bubble}, 32'd1);
        chk("mp_f_stall",  {31'd0, bus.f_stall},  32'd1);
        chk("mp_d_stall",  {31'd0, bus.d_stall},  32'd0);
        tick();
        benign();

        // Exception in M, then in W
        bus.m_stat = 3'd3; bus.e_icode = 4'h6;
        #1;
        chk("exc_m_bubble", {31'd0, bus.m_bubble}, 32'd1);
        chk("exc_cc_en",    {31'd0, bus.cc_en},    32'd0);
        tick();
        bus.m_stat = 3'd1; bus.w_stat = 3'd3;
        #1;
        chk("exc_w_stall", {31'd0, bus.w_stall}, 32'd1);
        tick();
        benign();
        chk("exc_halted", {31'd0, bus.halted},     32'd1);
        chk("exc_final",  {29'd0, bus.final_stat}, 32'd3);
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        tick();
        chk("go_ignored", {31'd0, bus.halted}, 32'd1);

        // Reset from halted, run 10 cycles, reset mid-run, restart
        async_reset();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        repeat (10) tick();
        chk("run10_cyc", bus.cyc_cnt, cexp(32'd10));
        async_reset();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        repeat (3) tick();
        chk("restart_cyc", bus.cyc_cnt, cexp(32'd3));

        // Randomized pipeline traffic
        halt_ticks = 0;
        for (int i = 0; i < 800; i++) begin
            bus.go      = ($urandom_range(0, 3) == 0);
            bus.d_icode = icodes[$urandom_range(0, 6)];
            bus.d_srcA  = rnd_reg();
            bus.d_srcB  = rnd_reg();
            bus.e_icode = icodes[$urandom_range(0, 6)];
            bus.e_dstM  = rnd_reg();
            bus.e_cnd   = 1'($urandom_range(0, 1));
            bus.m_icode = icodes[$urandom_range(0, 6)];
            bus.m_stat  = rnd_stat(6);
            bus.w_stat  = rnd_stat(25);
            bus.w_icode = icodes[$urandom_range(0, 6)];
            tick();
            if (m_mode == 2) halt_ticks++;
            if (halt_ticks > 3) begin
                halt_ticks = 0;
                benign();
                async_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
